multi_sprite_draw: RTL and testbench

Parametrised multi-object sprite renderer for the VGA path. It holds a double-buffered table of up to NUM_OBJ object positions and visibility flags, and resolves which object covers the current scan pixel. The lowest-index visible object always wins. It then outputs that object's bitmap colour and mask through a 2-stage pipeline. It sits between the game-logic object controllers, which write positions, and the VGA priority mux, which consumes `drawing_request`/`mVGA_RGB`.

---
 rtl/sprite_pkg.sv | 49 ++++
 rtl/multi_sprite_draw_if.sv | 32 +++
 rtl/sprite_hit_sel.sv | 66 ++++++
 rtl/multi_sprite_draw.sv | 136 +++++++++++++
 tb/tb_multi_sprite_draw.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and bitmap constants for the multi-object sprite renderer.
// Optional feature macro: SPRITE_MIRROR_EN adds a per-object horizontal mirror flag.
package sprite_pkg;

  localparam int unsigned DEF_NUM_OBJ = 30;
  localparam int unsigned DEF_OBJ_W   = 20;
  localparam int unsigned DEF_OBJ_H   = 20;
  localparam int unsigned DEF_COORD_W = 11;
  localparam int unsigned DEF_COLOR_W = 8;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic                   visible;
`ifdef SPRITE_MIRROR_EN
    logic                   mirror;
`endif
  } obj_entry_t;

  typedef logic [DEF_OBJ_H-1:0][DEF_OBJ_W-1:0]                  mask_t;
  typedef logic [DEF_OBJ_H-1:0][DEF_OBJ_W-1:0][DEF_COLOR_W-1:0] colors_t;

  // Rows are indexed top-first: MASK[by][bx].
  function automatic mask_t gen_mask();
    mask_t m;
    m = '0;
    for (int r = 0; r < int'(DEF_OBJ_H); r++) begin
      for (int c = 0; c < int'(DEF_OBJ_W); c++) begin
        m[r][c] = (((r ^ c) & 3) != 3);
      end
    end
    return m;
  endfunction

  function automatic colors_t gen_colors();
    colors_t p;
    p = '0;
    for (int r = 0; r < int'(DEF_OBJ_H); r++) begin
      for (int c = 0; c < int'(DEF_OBJ_W); c++) begin
        p[r][c] = DEF_COLOR_W'((r * int'(DEF_OBJ_W) + c) * 7 + 13);
      end
    end
    return p;
  endfunction

  localparam mask_t   MASK   = gen_mask();
  localparam colors_t COLORS = gen_colors();

endpackage

// File: rtl/multi_sprite_draw_if.sv
// Write port from the game-logic object controllers into the shadow table.
// Optional feature macro: SPRITE_MIRROR_EN adds wr_mirror.
interface multi_sprite_draw_if #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned COORD_W = 11
);
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic               wr_visible;
  logic               wr_ready;
`ifdef SPRITE_MIRROR_EN
  logic               wr_mirror;
`endif

  modport master (
    output wr_en, wr_idx, wr_x, wr_y, wr_visible,
`ifdef SPRITE_MIRROR_EN
    output wr_mirror,
`endif
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_idx, wr_x, wr_y, wr_visible,
`ifdef SPRITE_MIRROR_EN
    input  wr_mirror,
`endif
    output wr_ready
  );
endinterface

// File: rtl/sprite_hit_sel.sv
// Stage-1 combinational hit test, lowest-index priority select and overlap detect.
// Optional feature macro: SPRITE_MIRROR_EN exports the winner's mirror flag.
module sprite_hit_sel
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_OBJ = DEF_NUM_OBJ,
  parameter int unsigned OBJ_W   = DEF_OBJ_W,
  parameter int unsigned OBJ_H   = DEF_OBJ_H,
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned BX_W    = 5,
  parameter int unsigned BY_W    = 5
) (
  input  obj_entry_t         i_tab [NUM_OBJ],
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic [BX_W-1:0]    o_bx,
  output logic [BY_W-1:0]    o_by,
`ifdef SPRITE_MIRROR_EN
  output logic               o_mirror,
`endif
  output logic               o_overlap
);

  logic [COORD_W:0]   w_x_end, w_y_end;
  logic               w_hit_i;
  logic [COORD_W-1:0] w_win_x, w_win_y;

  // End bounds carry an extra bit so objects near the limit clip instead of wrapping.
  always_comb begin
    w_x_end   = '0;
    w_y_end   = '0;
    w_hit_i   = 1'b0;
    o_hit     = 1'b0;
    o_idx     = '0;
    o_overlap = 1'b0;
    w_win_x   = i_x;
    w_win_y   = i_y;
`ifdef SPRITE_MIRROR_EN
    o_mirror  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      w_x_end = {1'b0, i_tab[i].x} + (COORD_W+1)'(OBJ_W);
      w_y_end = {1'b0, i_tab[i].y} + (COORD_W+1)'(OBJ_H);
      w_hit_i = i_tab[i].visible &&
                (i_x >= i_tab[i].x) && ({1'b0, i_x} < w_x_end) &&
                (i_y >= i_tab[i].y) && ({1'b0, i_y} < w_y_end);
      if (w_hit_i && o_hit) o_overlap = 1'b1;
      if (w_hit_i && !o_hit) begin
        o_hit   = 1'b1;
        o_idx   = IDX_W'(i);
        w_win_x = i_tab[i].x;
        w_win_y = i_tab[i].y;
`ifdef SPRITE_MIRROR_EN
        o_mirror = i_tab[i].mirror;
`endif
      end
    end
    // With no hit the window origin is the pixel itself, so offsets are zero.
    o_bx = BX_W'(i_x - w_win_x);
    o_by = BY_W'(i_y - w_win_y);
  end

endmodule

// File: rtl/multi_sprite_draw.sv
// Double-buffered multi-object sprite renderer with a 2-stage pixel pipeline.
// Optional feature macro: SPRITE_MIRROR_EN enables per-object horizontal mirroring.
module multi_sprite_draw
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_OBJ = DEF_NUM_OBJ,
  parameter int unsigned OBJ_W   = DEF_OBJ_W,
  parameter int unsigned OBJ_H   = DEF_OBJ_H,
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned COLOR_W = DEF_COLOR_W,
  parameter int unsigned IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [COORD_W-1:0]  oCoord_X,
  input  logic [COORD_W-1:0]  oCoord_Y,
  input  logic                startOfFrame,
  multi_sprite_draw_if.slave  wr_bus,
  output logic                drawing_request,
  output logic [COLOR_W-1:0]  mVGA_RGB,
  output logic [IDX_W-1:0]    hit_idx,
  output logic                overlap
);

  localparam int unsigned BX_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
  localparam int unsigned BY_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;

  obj_entry_t r_shadow [NUM_OBJ];
  obj_entry_t r_active [NUM_OBJ];
  obj_entry_t w_entry;
  logic       w_wr_acc;

  // A swap cycle stalls the writer so the write lands after the copy.
  assign wr_bus.wr_ready = !startOfFrame;
  assign w_wr_acc = wr_bus.wr_en && !startOfFrame && (32'(wr_bus.wr_idx) < NUM_OBJ);

  always_comb begin
    w_entry         = '0;
    w_entry.x       = wr_bus.wr_x;
    w_entry.y       = wr_bus.wr_y;
    w_entry.visible = wr_bus.wr_visible;
`ifdef SPRITE_MIRROR_EN
    w_entry.mirror  = wr_bus.wr_mirror;
`endif
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (startOfFrame) begin
        for (int i = 0; i < int'(NUM_OBJ); i++) r_active[i] <= r_shadow[i];
      end
      if (w_wr_acc) r_shadow[wr_bus.wr_idx] <= w_entry;
    end
  end

  logic             w_hit, w_ovl;
  logic [IDX_W-1:0] w_idx;
  logic [BX_W-1:0]  w_bx, w_bx_eff;
  logic [BY_W-1:0]  w_by;
`ifdef SPRITE_MIRROR_EN
  logic             w_mirror;
`endif

  sprite_hit_sel #(
    .NUM_OBJ (NUM_OBJ),
    .OBJ_W   (OBJ_W),
    .OBJ_H   (OBJ_H),
    .COORD_W (COORD_W),
    .IDX_W   (IDX_W),
    .BX_W    (BX_W),
    .BY_W    (BY_W)
  ) u_hit_sel (
    .i_tab     (r_active),
    .i_x       (oCoord_X),
    .i_y       (oCoord_Y),
    .o_hit     (w_hit),
    .o_idx     (w_idx),
    .o_bx      (w_bx),
    .o_by      (w_by),
`ifdef SPRITE_MIRROR_EN
    .o_mirror  (w_mirror),
`endif
    .o_overlap (w_ovl)
  );

  always_comb begin
    w_bx_eff = w_bx;
`ifdef SPRITE_MIRROR_EN
    if (w_hit && w_mirror) w_bx_eff = BX_W'(OBJ_W - 1) - w_bx;
`endif
  end

  logic             r_s1_hit, r_s1_ovl;
  logic [IDX_W-1:0] r_s1_idx;
  logic [BX_W-1:0]  r_s1_bx;
  logic [BY_W-1:0]  r_s1_by;

  logic               r_draw, r_ovl;
  logic [COLOR_W-1:0] r_rgb;
  logic [IDX_W-1:0]   r_idx;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s1_hit <= 1'b0;
      r_s1_ovl <= 1'b0;
      r_s1_idx <= '0;
      r_s1_bx  <= '0;
      r_s1_by  <= '0;
      r_draw   <= 1'b0;
      r_ovl    <= 1'b0;
      r_rgb    <= '0;
      r_idx    <= '0;
    end else begin
      r_s1_hit <= w_hit;
      r_s1_ovl <= w_ovl;
      r_s1_idx <= w_idx;
      r_s1_bx  <= w_bx_eff;
      r_s1_by  <= w_by;
      r_draw   <= r_s1_hit & MASK[r_s1_by][r_s1_bx];
      r_rgb    <= COLORS[r_s1_by][r_s1_bx];
      r_idx    <= r_s1_idx;
      r_ovl    <= r_s1_ovl;
    end
  end

  assign drawing_request = r_draw;
  assign mVGA_RGB        = r_rgb;
  assign hit_idx         = r_idx;
  assign overlap         = r_ovl;

endmodule

// File: tb/tb_multi_sprite_draw.sv
// Self-checking bench for multi_sprite_draw: directed vector table, hand sequences and
// random stream against a behavioural model. Honours SPRITE_MIRROR_EN when defined.
module tb_multi_sprite_draw;
  import sprite_pkg::*;

  localparam int NOBJ = 30;
  localparam int OW   = 20;
  localparam int OH   = 20;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [10:0] cx, cy;
  logic        sof;
  logic        draw, ovl;
  logic [7:0]  rgb;
  logic [4:0]  hidx;

  multi_sprite_draw_if #(.IDX_W(5), .COORD_W(11)) wr_bus ();

  multi_sprite_draw dut (
    .CLK             (CLK),
    .RESETn          (RESETn),
    .oCoord_X        (cx),
    .oCoord_Y        (cy),
    .startOfFrame    (sof),
    .wr_bus          (wr_bus),
    .drawing_request (draw),
    .mVGA_RGB        (rgb),
    .hit_idx         (hidx),
    .overlap         (ovl)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       draw;
    logic [7:0] rgb;
    logic [4:0] idx;
    logic       ovl;
  } exp_t;

  typedef struct {
    int   x;
    int   y;
    exp_t e;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model of both object tables.
  int sh_x [NOBJ], sh_y [NOBJ], sh_v [NOBJ], sh_m [NOBJ];
  int ac_x [NOBJ], ac_y [NOBJ], ac_v [NOBJ], ac_m [NOBJ];

  function automatic exp_t mk(int d, int c, int i, int o);
    exp_t e;
    e.draw = d[0];
    e.rgb  = 8'(c);
    e.idx  = 5'(i);
    e.ovl  = o[0];
    return e;
  endfunction

  function automatic vec_t mkv(int x, int y, exp_t e);
    vec_t v;
    v.x = x;
    v.y = y;
    v.e = e;
    return v;
  endfunction

  function automatic exp_t ref_px(int x, int y);
    int win = -1;
    int cnt = 0;
    int bx  = 0;
    int by  = 0;
    for (int i = 0; i < NOBJ; i++) begin
      if (ac_v[i] != 0 && x >= ac_x[i] && x < ac_x[i] + OW && y >= ac_y[i] && y < ac_y[i] + OH)
      begin
        cnt++;
        if (win < 0) win = i;
      end
    end
    if (win >= 0) begin
      bx = x - ac_x[win];
      by = y - ac_y[win];
      if (ac_m[win] != 0) bx = OW - 1 - bx;
    end
    return mk((win >= 0) ? int'(MASK[by][bx]) : 0, int'(COLORS[by][bx]),
              (win >= 0) ? win : 0, (cnt >= 2) ? 1 : 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NOBJ; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_v[i] = 0; sh_m[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_v[i] = 0; ac_m[i] = 0;
    end
  endtask

  // Advance one clock, updating the model with what the edge will do.
  task automatic tick();
    if (sof) begin
      for (int i = 0; i < NOBJ; i++) begin
        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_v[i] = sh_v[i]; ac_m[i] = sh_m[i];
      end
    end else if (wr_bus.wr_en && int'(wr_bus.wr_idx) < NOBJ) begin
      sh_x[wr_bus.wr_idx] = int'(wr_bus.wr_x);
      sh_y[wr_bus.wr_idx] = int'(wr_bus.wr_y);
      sh_v[wr_bus.wr_idx] = int'(wr_bus.wr_visible);
`ifdef SPRITE_MIRROR_EN
      sh_m[wr_bus.wr_idx] = int'(wr_bus.wr_mirror);
`endif
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string nm, exp_t e);
    total++;
    if ({draw, rgb, hidx, ovl} !== e) begin
      bad++;
      $display("FAIL %s: got draw=%0d rgb=%0d idx=%0d ovl=%0d, want draw=%0d rgb=%0d idx=%0d ovl=%0d",
               nm, draw, rgb, hidx, ovl, e.draw, e.rgb, e.idx, e.ovl);
    end
  endtask

  task automatic chk_bit(string nm, logic got, logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic set_wr(int idx, int x, int y, int vis, int mir);
    wr_bus.wr_idx     = 5'(idx);
    wr_bus.wr_x       = 11'(x);
    wr_bus.wr_y       = 11'(y);
    wr_bus.wr_visible = vis[0];
`ifdef SPRITE_MIRROR_EN
    wr_bus.wr_mirror  = mir[0];
`else
    if (mir != 0) $display("note: mirror flag dropped in this build");
`endif
  endtask

  task automatic do_write(int idx, int x, int y, int vis, int mir);
    bit done = 0;
    bit acc;
    set_wr(idx, x, y, vis, mir);
    wr_bus.wr_en = 1'b1;
    for (int k = 0; k < 8 && !done; k++) begin
      acc = wr_bus.wr_ready;
      tick();
      done = acc;
    end
    wr_bus.wr_en = 1'b0;
    chk_bit("write_accept", done, 1'b1);
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic scan(int x, int y);
    cx = 11'(x);
    cy = 11'(y);
    tick();
    tick();
  endtask

  vec_t tv [10];
  exp_t q [$];
  exp_t nohit;

  initial begin
    bit acc_prev;
    int k;
    RESETn = 1'b0;
    cx = '0; cy = '0; sof = 1'b0;
    wr_bus.wr_en = 1'b0;
    set_wr(0, 0, 0, 0, 0);
    model_clear();
    nohit = mk(0, int'(COLORS[0][0]), 0, 0);

    // Reset state
    #12;
    chk("reset_out", mk(0, 0, 0, 0));
    chk_bit("reset_ready", wr_bus.wr_ready, 1'b1);
    @(negedge CLK);
    RESETn = 1'b1;
    tick();

    // Directed table
    do_write(3, 100, 50, 1, 0);
    do_write(5, 200, 200, 1, 0);
    do_write(2, 200, 200, 1, 0);
    do_write(1, 2040, 0, 1, 0);
    do_write(31, 100, 50, 1, 0);
    frame();

    tv[0] = mkv(100, 50,  mk(int'(MASK[0][0]),   int'(COLORS[0][0]),   3, 0));
    tv[1] = mkv(120, 50,  nohit);
    tv[2] = mkv(205, 210, mk(int'(MASK[10][5]),  int'(COLORS[10][5]),  2, 1));
    tv[3] = mkv(2047, 0,  mk(int'(MASK[0][7]),   int'(COLORS[0][7]),   1, 0));
    tv[4] = mkv(3, 0,     nohit);
    tv[5] = mkv(119, 69,  mk(int'(MASK[19][19]), int'(COLORS[19][19]), 3, 0));
    tv[6] = mkv(219, 219, mk(int'(MASK[19][19]), int'(COLORS[19][19]), 2, 1));
    tv[7] = mkv(220, 200, nohit);
    tv[8] = mkv(99, 50,   nohit);
    tv[9] = mkv(101, 50,  mk(int'(MASK[0][1]),   int'(COLORS[0][1]),   3, 0));
    for (int i = 0; i < 10; i++) begin
      scan(tv[i].x, tv[i].y);
      chk($sformatf("vec%0d", i), tv[i].e);
    end

    // Shadow isolation, then write stalled by a swap
    do_write(0, 10, 10, 1, 0);
    scan(10, 10);
    chk("shadow_iso", nohit);
    set_wr(6, 300, 300, 1, 0);
    wr_bus.wr_en = 1'b1;
    sof = 1'b1;
    #1;
    chk_bit("stall_ready", wr_bus.wr_ready, 1'b0);
    tick();
    sof = 1'b0;
    #1;
    chk_bit("ready_after", wr_bus.wr_ready, 1'b1);
    tick();
    wr_bus.wr_en = 1'b0;
    scan(300, 300);
    chk("stalled_not_active", nohit);
    scan(10, 10);
    chk("slot0_swapped", mk(int'(MASK[0][0]), int'(COLORS[0][0]), 0, 0));
    frame();
    scan(300, 300);
    chk("stalled_after_swap", mk(int'(MASK[0][0]), int'(COLORS[0][0]), 6, 0));

`ifdef SPRITE_MIRROR_EN
    do_write(4, 0, 0, 1, 1);
    frame();
    scan(0, 0);
    chk("mirror", mk(int'(MASK[0][OW-1]), int'(COLORS[0][OW-1]), 4, 0));
`endif

    // Reset mid-stream
    scan(100, 50);
    chk_bit("pre_reset_draw", draw, 1'b1);
    RESETn = 1'b0;
    #1;
    chk("async_reset", mk(0, 0, 0, 0));
    model_clear();
    #3;
    RESETn = 1'b1;
    scan(100, 50);
    chk("post_reset", nohit);
    frame();
    scan(100, 50);
    chk("post_reset_swap", nohit);

    // Random stream against the model, one pixel per cycle
    acc_prev = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (acc_prev || !wr_bus.wr_en) begin
        wr_bus.wr_en = ($urandom % 3) == 0;
        set_wr(int'($urandom_range(0, 31)),
               ($urandom % 5 == 0) ? int'($urandom_range(2028, 2047)) : int'($urandom_range(0, 120)),
               ($urandom % 5 == 0) ? int'($urandom_range(2028, 2047)) : int'($urandom_range(0, 120)),
               int'($urandom % 4 != 0), int'($urandom % 2));
      end
      sof = ($urandom % 12) == 0;
      acc_prev = wr_bus.wr_en && !sof;
      k = int'($urandom % NOBJ);
      if ($urandom % 4 != 0) begin
        cx = 11'(((ac_x[k] + int'($urandom_range(0, 24)) - 2) < 0) ? 0 :
                 ((ac_x[k] + int'($urandom_range(0, 24)) - 2) > 2047) ? 2047 :
                 (ac_x[k] + int'($urandom_range(0, 22)) - 1));
        cy = 11'(((ac_y[k] + int'($urandom_range(0, 22)) - 1) > 2047) ? 2047 :
                 (ac_y[k] + int'($urandom_range(0, 21))));
      end else begin
        cx = 11'($urandom);
        cy = 11'($urandom);
      end
      q.push_back(ref_px(int'(cx), int'(cy)));
      tick();
      if (q.size() == 2) chk("rand", q.pop_front());
    end
    sof = 1'b0;
    wr_bus.wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
